mc_alu: RTL and testbench

MC_ALU -- requirements
Module: mc_alu

---
 rtl/mc_alu_pkg.sv | 28 ++
 rtl/mc_mul_seq.sv | 70 +++++++
 rtl/mc_alu.sv | 144 ++++++++++++++
 tb/tb_mc_alu.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_alu_pkg.sv
// rtl/mc_alu_pkg.sv - shared op codes and FSM state encoding for mc_alu
//
// Purpose: the operation select and controller state types that both the
// ALU top and its testbench import.
// Ports: none (package).

package mc_alu_pkg;

  // ADD/SUB/AND/OR encodings are frozen; new ops are only ever appended.
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLT = 4'd5,
    OP_SLL = 4'd6,
    OP_SRL = 4'd7,
    OP_MUL = 4'd8
  } op_code;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mc_mul_seq.sv
// rtl/mc_mul_seq.sv - iterative shift-add unsigned multiplier, one bit per cycle
//
// Purpose: computes the full 2*WIDTH-bit unsigned product of i_a and i_b over
// WIDTH clock edges after a one-cycle i_start.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset, aborts any product in flight
//   i_start    load operands and begin (ignored rules belong to the caller)
//   i_a, i_b   multiplicand / multiplier, sampled with i_start
//   o_done     high during the final iteration cycle
//   o_product  product value that the final iteration produces (valid with o_done)

module mc_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic               r_busy;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_last;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_last     = r_busy && (r_cnt == LAST);

  // The caller registers the product on the same edge as the last iteration,
  // so the combinational next-accumulator value is exported instead of r_acc.
  assign o_done    = w_last;
  assign o_product = w_acc_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (w_last) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mc_alu.sv
// rtl/mc_alu.sv - multi-cycle ALU with valid/ready handshake
//
// Purpose: single-cycle ADD/SUB/AND/OR/XOR/SLT/SLL/SRL and an iterative MUL,
// sequenced by an IDLE/BUSY/DONE controller; one request in flight at a time.
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   valid_i / ready_o  request handshake (ready_o high only in IDLE)
//   rs_i, rt_i, op_i   operands and operation, captured on accept
//   valid_o / ready_i  result handshake (outputs held in DONE until ready_i)
//   result_o           result
//   zero_o             result_o == 0
//   ovf_o              signed overflow (ADD/SUB) or truncated product (MUL)

module mc_alu
  import mc_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  op_code           op_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             ovf_o
);

  localparam int SH_W = $clog2(WIDTH);

  state_e               r_state;
  state_e               w_next;
  logic [WIDTH-1:0]     r_result;
  logic                 r_zero;
  logic                 r_ovf;

  logic                 w_accept;
  logic                 w_mul_start;
  logic                 w_mul_done;
  logic [2*WIDTH-1:0]   w_mul_product;
  logic [WIDTH-1:0]     w_sum;
  logic [WIDTH-1:0]     w_diff;
  logic [SH_W-1:0]      w_shamt;
  logic [WIDTH-1:0]     w_res;
  logic                 w_ovf;

  assign w_accept    = valid_i && (r_state == ST_IDLE);
  assign w_mul_start = w_accept && (op_i == OP_MUL);
  assign w_sum       = rs_i + rt_i;
  assign w_diff      = rs_i - rt_i;
  assign w_shamt     = rt_i[SH_W-1:0];

  mc_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_mul_start),
    .i_a       (rs_i),
    .i_b       (rt_i),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );

  // Single-cycle datapath; undefined codes fall through to zero / no overflow.
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (op_i)
      OP_ADD: begin
        w_res = w_sum;
        // Like-signed operands producing an opposite-signed sum.
        w_ovf = (rs_i[WIDTH-1] == rt_i[WIDTH-1]) && (w_sum[WIDTH-1] != rs_i[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff;
        w_ovf = (rs_i[WIDTH-1] != rt_i[WIDTH-1]) && (w_diff[WIDTH-1] != rs_i[WIDTH-1]);
      end
      OP_AND: w_res = rs_i & rt_i;
      OP_OR:  w_res = rs_i | rt_i;
      OP_XOR: w_res = rs_i ^ rt_i;
      OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(rs_i) < $signed(rt_i))};
      OP_SLL: w_res = rs_i << w_shamt;
      OP_SRL: w_res = rs_i >> w_shamt;
      default: begin
        w_res = '0;
        w_ovf = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_next  = r_state;
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          w_next = (op_i == OP_MUL) ? ST_BUSY : ST_DONE;
        end
      end
      ST_BUSY: begin
        if (w_mul_done) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        valid_o = 1'b1;
        if (ready_i) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept && (op_i != OP_MUL)) begin
        r_result <= w_res;
        r_zero   <= (w_res == '0);
        r_ovf    <= w_ovf;
      end else if ((r_state == ST_BUSY) && w_mul_done) begin
        r_result <= w_mul_product[WIDTH-1:0];
        r_zero   <= (w_mul_product[WIDTH-1:0] == '0);
        r_ovf    <= |w_mul_product[2*WIDTH-1:WIDTH];
      end
    end
  end

  assign result_o = r_result;
  assign zero_o   = r_zero;
  assign ovf_o    = r_ovf;

endmodule

// File: tb/tb_mc_alu.sv
// tb/tb_mc_alu.sv - scoreboard testbench for mc_alu (WIDTH 32 and WIDTH 8)

module tb_mc_alu;
  import mc_alu_pkg::*;

  typedef struct {
    logic [63:0] res;
    logic        zero;
    logic        ovf;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;

  logic        reset, valid_i, ready_o, valid_o, ready_i, zero_o, ovf_o;
  logic [31:0] rs_i, rt_i, result_o;
  op_code      op_i;

  logic        reset8, valid_i8, ready_o8, valid_o8, ready_i8, zero_o8, ovf_o8;
  logic [7:0]  rs_i8, rt_i8, result_o8;
  op_code      op_i8;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t q32[$];
  exp_t q8[$];
  exp_t cur32;
  bit   have32 = 1'b0;
  bit   rdy_auto = 1'b0;

  mc_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
    .rs_i(rs_i), .rt_i(rt_i), .op_i(op_i), .valid_o(valid_o),
    .ready_i(ready_i), .result_o(result_o), .zero_o(zero_o), .ovf_o(ovf_o)
  );

  mc_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset8), .valid_i(valid_i8), .ready_o(ready_o8),
    .rs_i(rs_i8), .rt_i(rt_i8), .op_i(op_i8), .valid_o(valid_o8),
    .ready_i(ready_i8), .result_o(result_o8), .zero_o(zero_o8), .ovf_o(ovf_o8)
  );

  initial forever begin
    #5 clk = 1'b1;
    cyc++;
    #5 clk = 1'b0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: signed values as integers, products as wide unsigned numbers.
  function automatic void model(input int w, input int op, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] res,
                                output logic ovf);
    logic [63:0]  mask;
    longint       sa, sb, full, hi, lo;
    logic [127:0] p;
    int           sh;
    mask = (64'd1 << w) - 64'd1;
    hi   = (longint'(1) << (w - 1)) - 1;
    lo   = -(longint'(1) << (w - 1));
    sa   = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb   = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    sh   = int'(b % 64'(w));
    res  = '0;
    ovf  = 1'b0;
    case (op)
      0: begin full = sa + sb; res = 64'(full) & mask; ovf = (full > hi) || (full < lo); end
      1: begin full = sa - sb; res = 64'(full) & mask; ovf = (full > hi) || (full < lo); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = (sa < sb) ? 64'd1 : 64'd0;
      6: res = (a << sh) & mask;
      7: res = a >> sh;
      8: begin
        p   = {64'd0, a} * {64'd0, b};
        res = p[63:0] & mask;
        ovf = (p >> w) != 0;
      end
      default: res = '0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Random consumer back-pressure unless a directed section owns ready_i.
  initial forever begin
    @(posedge clk);
    #2;
    if (rdy_auto) ready_i = ($urandom_range(0, 3) != 0);
  end

  initial forever begin
    @(negedge clk);
    if (reset) begin
      have32 = 1'b0;
    end else if (valid_o) begin
      if (!have32) begin
        if (q32.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          cur32  = q32.pop_front();
          have32 = 1'b1;
          check("latency", 64'(cyc - cur32.acc), 64'(cur32.lat));
        end
      end
      if (have32) begin
        check("result", result_o, cur32.res);
        check("zero", zero_o, cur32.zero);
        check("ovf", ovf_o, cur32.ovf);
        if (ready_i) have32 = 1'b0;
      end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset8 && valid_o8) begin
      if (q8.size() == 0) begin
        check("unexpected_valid8", 1, 0);
      end else begin
        e = q8.pop_front();
        check("result8", result_o8, e.res);
        check("zero8", zero_o8, e.zero);
        check("ovf8", ovf_o8, e.ovf);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue32(input int op, input logic [31:0] a, input logic [31:0] b,
                         input bit directed, input logic [31:0] er, input logic ez,
                         input logic eo);
    exp_t        e;
    logic [63:0] mr;
    logic        mo;
    int          n;
    n       = 0;
    valid_i = 1'b1;
    op_i    = op_code'(4'(op));
    rs_i    = a;
    rt_i    = b;
    @(negedge clk);
    while (!ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      check("accept_timeout", 0, 1);
      valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    model(32, op, {32'd0, a}, {32'd0, b}, mr, mo);
    if (directed) begin
      e.res = {32'd0, er}; e.zero = ez; e.ovf = eo;
    end else begin
      e.res = mr; e.zero = (mr == 0); e.ovf = mo;
    end
    e.lat = (op == 8) ? 32 : 0;
    e.acc = cyc;
    q32.push_back(e);
    valid_i = 1'b0;
  endtask

  task automatic issue8(input int op, input logic [7:0] a, input logic [7:0] b,
                        input bit directed, input logic [7:0] er, input logic ez,
                        input logic eo);
    exp_t        e;
    logic [63:0] mr;
    logic        mo;
    int          n;
    n        = 0;
    valid_i8 = 1'b1;
    op_i8    = op_code'(4'(op));
    rs_i8    = a;
    rt_i8    = b;
    @(negedge clk);
    while (!ready_o8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o8) begin
      check("accept_timeout8", 0, 1);
      valid_i8 = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    model(8, op, {56'd0, a}, {56'd0, b}, mr, mo);
    if (directed) begin
      e.res = {56'd0, er}; e.zero = ez; e.ovf = eo;
    end else begin
      e.res = mr; e.zero = (mr == 0); e.ovf = mo;
    end
    e.lat = 0;
    e.acc = cyc;
    q8.push_back(e);
    valid_i8 = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q32.size() != 0 || have32 || q8.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", (q32.size() != 0 || have32 || q8.size() != 0), 0);
  endtask

  initial begin
    int          n;
    bit          seen;
    logic [31:0] ra, rb;
    reset = 1'b1; reset8 = 1'b1;
    valid_i = 1'b0; valid_i8 = 1'b0;
    ready_i = 1'b0; ready_i8 = 1'b1;
    op_i = OP_ADD; op_i8 = OP_ADD;
    rs_i = '0; rt_i = '0; rs_i8 = '0; rt_i8 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready_o", ready_o, 1);
    check("rst_valid_o", valid_o, 0);
    check("rst_result", result_o, 0);
    check("rst_zero", zero_o, 1);
    check("rst_ovf", ovf_o, 0);
    @(posedge clk);
    #1;
    reset = 1'b0; reset8 = 1'b0;
    rdy_auto = 1'b1;

    issue32(0, 32'd8, 32'd4, 1, 32'd12, 0, 0);
    issue32(1, 32'd4, 32'd8, 1, 32'hFFFF_FFFC, 0, 0);
    issue32(1, 32'd10, 32'd10, 1, 32'd0, 1, 0);
    issue32(0, 32'h7FFF_FFFF, 32'd1, 1, 32'h8000_0000, 0, 1);
    issue32(1, 32'h8000_0000, 32'd1, 1, 32'h7FFF_FFFF, 0, 1);
    issue32(5, 32'hFFFF_FFFF, 32'd1, 1, 32'd1, 0, 0);
    issue32(6, 32'd1, 32'h0000_0021, 1, 32'd2, 0, 0);
    issue32(12, 32'd5, 32'd5, 1, 32'd0, 1, 0);
    drain(500);

    // MUL with the consumer stalling after valid_o rises.
    @(posedge clk);
    #1;
    rdy_auto = 1'b0;
    ready_i  = 1'b0;
    issue32(8, 32'd7, 32'd6, 1, 32'd42, 0, 0);
    n = 0;
    @(negedge clk);
    while (!valid_o && n < 64) begin
      check("busy_ready_o", ready_o, 0);
      @(negedge clk);
      n++;
    end
    check("mul_valid", valid_o, 1);
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", valid_o, 1);
      check("stall_ready_o", ready_o, 0);
    end
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
    @(negedge clk);
    check("post_hs_ready_o", ready_o, 1);
    check("post_hs_valid_o", valid_o, 0);
    rdy_auto = 1'b1;

    // Reset pulsed ten cycles into a MUL must abort it without a result.
    @(posedge clk);
    #1;
    issue32(8, 32'h0001_2345, 32'h0000_0777, 0, 0, 0, 0);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q32.delete();
    @(negedge clk);
    check("abort_ready_o", ready_o, 1);
    check("abort_valid_o", valid_o, 0);
    check("abort_result", result_o, 0);
    check("abort_zero", zero_o, 1);
    check("abort_ovf", ovf_o, 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (valid_o) seen = 1'b1;
    end
    check("abort_no_valid", seen, 0);
    @(posedge clk);
    #1;
    issue32(3, 32'hFFFF_0000, 32'h0000_FFFF, 1, 32'hFFFF_FFFF, 0, 0);

    for (int i = 0; i < 80; i++) begin
      ra = pick();
      rb = pick();
      issue32(int'($urandom_range(0, 11)), ra, rb, 0, 0, 0, 0);
    end
    drain(2000);

    @(posedge clk);
    #1;
    issue8(6, 8'h81, 8'h09, 1, 8'h02, 0, 0);
    issue8(8, 8'd16, 8'd16, 1, 8'h00, 1, 1);
    issue8(0, 8'h7F, 8'h01, 1, 8'h80, 0, 1);
    for (int i = 0; i < 40; i++) begin
      ra = pick();
      rb = $urandom();
      issue8(int'($urandom_range(0, 11)), ra[7:0], rb[7:0], 0, 0, 0, 0);
    end
    drain(500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
